// File: rtl/rs_pkg.sv
// GF(2^m) helpers for the streaming RS syndrome block: constant-multiply
// matrices are elaborated here and folded into XOR networks by the users.
package rs_pkg;

  localparam int DEF_SYMBOL_WIDTH = 8;
  localparam int GF_MAX_W         = 16;

  typedef logic [DEF_SYMBOL_WIDTH-1:0] symbol_t;
  typedef logic [GF_MAX_W-1:0]         gf_word_t;
  typedef logic [GF_MAX_W:0]           gf_poly_t;
  typedef gf_word_t [GF_MAX_W-1:0]     gf_mat_t;

  function automatic int gf_order(input int m);
    return (1 << m) - 1;
  endfunction

  function automatic gf_word_t gf_xtime(input gf_word_t a, input int m, input gf_poly_t poly);
    gf_poly_t t;
    t = {a, 1'b0};
    if (t[m]) t = t ^ poly;
    return t[GF_MAX_W-1:0];
  endfunction

  function automatic gf_word_t gf_mul_const(input gf_word_t a, input int k, input int m,
                                            input gf_poly_t poly);
    gf_word_t r;
    int       kk;
    r  = a;
    kk = k % gf_order(m);
    for (int i = 0; i < kk; i++) r = gf_xtime(r, m, poly);
    return r;
  endfunction

  function automatic gf_word_t gf_alpha_pow(input int k, input int m = DEF_SYMBOL_WIDTH,
                                            input gf_poly_t poly = 17'h0011D);
    return gf_mul_const(gf_word_t'(1), k, m, poly);
  endfunction

  // Column i is alpha^k * x^i; the product is the XOR of columns selected by the input bits.
  function automatic gf_mat_t gf_const_matrix(input int k, input int m, input gf_poly_t poly);
    gf_mat_t mat;
    mat = '0;
    for (int i = 0; i < m; i++) mat[i] = gf_mul_const(gf_word_t'(1) << i, k, m, poly);
    return mat;
  endfunction

endpackage

// File: rtl/rs_gf_const_mul.sv
// Combinational multiply by the constant alpha^POWER in GF(2^SYMBOL_WIDTH).
module rs_gf_const_mul
  import rs_pkg::*;
#(
  parameter int                    SYMBOL_WIDTH = 8,
  parameter logic [SYMBOL_WIDTH:0] PRIM_POLY    = 9'h11D,
  parameter int                    POWER        = 1
) (
  input  logic [SYMBOL_WIDTH-1:0] a,
  output logic [SYMBOL_WIDTH-1:0] y
);

  localparam gf_poly_t POLY_EXT = gf_poly_t'(PRIM_POLY);
  localparam gf_mat_t  MAT      = gf_const_matrix(POWER, SYMBOL_WIDTH, POLY_EXT);

  always_comb begin
    y = '0;
    for (int i = 0; i < SYMBOL_WIDTH; i++)
      y = y ^ ({SYMBOL_WIDTH{a[i]}} & MAT[i][SYMBOL_WIDTH-1:0]);
  end

endmodule

// File: rtl/rs_syndrome_stream.sv
// Streaming Horner-rule RS syndrome calculator with registered valid/ready output.
// Build option: RS_SYN_ZERO_FLAG_EN enables the registered all-syndromes-zero flag.
module rs_syndrome_stream
  import rs_pkg::*;
#(
  parameter int                    SYMBOL_WIDTH = 8,
  parameter int                    N            = 18,
  parameter int                    NUM_SYN      = 2,
  parameter int                    FCR          = 1,
  parameter logic [SYMBOL_WIDTH:0] PRIM_POLY    = 9'h11D
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [SYMBOL_WIDTH-1:0]         in_data,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_SYN*SYMBOL_WIDTH-1:0] out_syn,
  output logic                            out_len_err,
  output logic                            out_zero
);

  localparam int SYN_W = NUM_SYN * SYMBOL_WIDTH;
  localparam int CNT_W = $clog2(N);

  logic             rdy_en;
  logic [CNT_W-1:0] cnt;
  logic [SYN_W-1:0] acc_q;
  logic [SYN_W-1:0] acc_mul;
  logic [SYN_W-1:0] acc_next;
  logic             accept;
  logic             last_pos;
  logic             terminal;

  for (genvar j = 0; j < NUM_SYN; j++) begin : g_syn
    rs_gf_const_mul #(
      .SYMBOL_WIDTH (SYMBOL_WIDTH),
      .PRIM_POLY    (PRIM_POLY),
      .POWER        (FCR + j)
    ) u_mul (
      .a (acc_q[j*SYMBOL_WIDTH +: SYMBOL_WIDTH]),
      .y (acc_mul[j*SYMBOL_WIDTH +: SYMBOL_WIDTH])
    );
    assign acc_next[j*SYMBOL_WIDTH +: SYMBOL_WIDTH] =
      acc_mul[j*SYMBOL_WIDTH +: SYMBOL_WIDTH] ^ in_data;
  end

  // rdy_en keeps in_ready low until the first edge after reset release.
  assign in_ready = rdy_en && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign last_pos = (cnt == CNT_W'(N - 1));
  assign terminal = accept && (in_last || last_pos);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt   <= '0;
    end else if (accept) begin
      if (terminal) begin
        acc_q <= '0;
        cnt   <= '0;
      end else begin
        acc_q <= acc_next;
        cnt   <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_syn     <= '0;
      out_len_err <= 1'b0;
    end else if (terminal) begin
      out_valid   <= 1'b1;
      out_syn     <= acc_next;
      out_len_err <= !last_pos || !in_last;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef RS_SYN_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        zero_q <= 1'b0;
    else if (terminal) zero_q <= (acc_next == '0);
  end

  assign out_zero = zero_q;
`else
  assign out_zero = 1'b0;
`endif

endmodule

// File: tb/tb_rs_syndrome_stream.sv
// Randomised bench for rs_syndrome_stream against a polynomial-evaluation reference model.
module tb_rs_syndrome_stream;

  localparam int W       = 8;
  localparam int N       = 18;
  localparam int NUM_SYN = 2;
  localparam int FCR     = 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [W-1:0]           in_data = '0;
  logic                   in_last = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [NUM_SYN*W-1:0]   out_syn;
  logic                   out_len_err;
  logic                   out_zero;

  int errors = 0;
  int checks = 0;
  bit rnd_ready = 1'b0;

  rs_syndrome_stream #(
    .SYMBOL_WIDTH (W),
    .N            (N),
    .NUM_SYN      (NUM_SYN),
    .FCR          (FCR),
    .PRIM_POLY    (9'h11D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_syn     (out_syn),
    .out_len_err (out_len_err),
    .out_zero    (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // GF(256) arithmetic, poly 0x11D
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gpow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < (e % 255); i++) r = gmul(r, 8'h02);
    return r;
  endfunction

  // S_j = r(alpha^(FCR+j)); symbol i of an L-symbol frame has degree L-1-i.
  function automatic logic [15:0] syndromes(input logic [7:0] q[$]);
    logic [15:0] res;
    logic [7:0]  s;
    res = '0;
    for (int j = 0; j < NUM_SYN; j++) begin
      s = '0;
      for (int i = 0; i < q.size(); i++)
        s = s ^ gmul(q[i], gpow((FCR + j) * (q.size() - 1 - i)));
      res[j*8 +: 8] = s;
    end
    return res;
  endfunction

  function automatic logic zero_exp(input logic [15:0] s);
`ifdef RS_SYN_ZERO_FLAG_EN
    return (s == 16'h0000);
`else
    return 1'b0 & s[0];
`endif
  endfunction

  // Cycle model: frame queue, pending result and expected outputs.
  logic [7:0]  m_q[$];
  bit          m_pend = 1'b0;
  bit          m_started = 1'b0;
  logic [15:0] m_syn = '0;
  logic        m_len = 1'b0;
  logic        m_zero = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_pend = 1'b0; m_started = 1'b0;
      m_syn = '0; m_len = 1'b0; m_zero = 1'b0;
    end else begin
      if (in_valid && m_started && (!m_pend || out_ready)) begin
        if (in_last || m_q.size() == N - 1) begin
          m_len = !(in_last && m_q.size() == N - 1);
          m_q.push_back(in_data);
          m_syn  = syndromes(m_q);
          m_zero = zero_exp(m_syn);
          m_pend = 1'b1;
          m_q.delete();
        end else begin
          m_q.push_back(in_data);
          if (out_ready) m_pend = 1'b0;
        end
      end else if (out_ready) begin
        m_pend = 1'b0;
      end
      m_started = 1'b1;
    end
  end

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      chk("in_ready", in_ready, m_started && (!m_pend || out_ready));
      chk("out_valid", out_valid, m_pend);
      if (m_pend) begin
        chk("out_syn", out_syn, m_syn);
        chk("out_len_err", out_len_err, m_len);
        chk("out_zero", out_zero, m_zero);
      end
    end
  end

  always @(negedge clk) if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);

  task automatic send_sym(input logic [7:0] d, input logic l);
    int budget;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    #1;
    budget = 0;
    while (!in_ready) begin
      budget++;
      if (budget > 200) begin
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk); #1;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
    end
  endtask

  logic [7:0] fr[$];

  task automatic send_frame(input bit with_last, input bit gaps);
    for (int i = 0; i < fr.size(); i++) begin
      if (gaps && $urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      send_sym(fr[i], with_last && (i == fr.size() - 1));
    end
  endtask

  task automatic fill(input int len, input int kind);
    fr.delete();
    for (int i = 0; i < len; i++)
      fr.push_back(kind == 0 ? 8'h00 : 8'($urandom_range(0, 255)));
  endtask

  logic [15:0] held;

  initial begin
    #1 rst_n = 1'b0;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_syn", out_syn, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // all-zero codeword
    fill(N, 0);
    send_frame(1'b1, 1'b0);
    idle(1);
    chk("zero_syn", out_syn, 16'h0000);
    chk("zero_len", out_len_err, 0);
    chk("zero_valid", out_valid, 1);
`ifdef RS_SYN_ZERO_FLAG_EN
    chk("zero_flag", out_zero, 1);
`endif

    // single error at highest degree, then back-to-back degree-0 error frame
    fill(N, 0); fr[0] = 8'h01;
    send_frame(1'b1, 1'b0);
    @(negedge clk); #2;
    chk("e17_syn", out_syn, 16'h4E98);
    chk("e17_zero", out_zero, 0);
    fill(N, 0); fr[N-1] = 8'h5A;
    send_frame(1'b1, 1'b0);
    idle(1);
    chk("e0_syn", out_syn, 16'h5A5A);

    // backpressure: pending result held while the next frame stalls
    fill(N, 1);
    held = syndromes(fr);
    send_frame(1'b1, 1'b0);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h33; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("bp_stall", in_ready, 0);
      chk("bp_hold", out_syn, held);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #2 chk("bp_release", in_ready, 1);
    @(posedge clk);
    fill(N - 1, 1);
    send_frame(1'b1, 1'b0);
    idle(2);

    // early in_last on symbol 10
    fill(10, 1);
    send_frame(1'b1, 1'b0);
    idle(1);
    chk("early_len", out_len_err, 1);
    chk("early_valid", out_valid, 1);

    // missing in_last; the 19th symbol opens a fresh, correct frame
    fill(N, 1);
    send_frame(1'b0, 1'b0);
    idle(1);
    chk("nolast_len", out_len_err, 1);
    fill(N, 1);
    send_frame(1'b1, 1'b0);
    idle(1);
    chk("fresh_len", out_len_err, 0);

    // async reset at symbol 7
    fill(7, 1); fr[0] = 8'h01;
    send_frame(1'b1, 1'b0);
    idle(1);
    fill(7, 1);
    send_frame(1'b0, 1'b0);
    #3 rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_syn", out_syn, 0);
    chk("arst_len", out_len_err, 0);
    chk("arst_zero", out_zero, 0);
    chk("arst_ready", in_ready, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    fill(N, 0);
    send_frame(1'b1, 1'b0);
    idle(1);
    chk("post_rst_syn", out_syn, 0);
    chk("post_rst_len", out_len_err, 0);

    // randomised frames with gaps and random out_ready
    rnd_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int k;
      k = $urandom_range(0, 5);
      if (k == 0)      begin fill($urandom_range(1, N - 1), 1); send_frame(1'b1, 1'b1); end
      else if (k == 1) begin fill(N, 1); send_frame(1'b0, 1'b1); end
      else if (k == 2) begin fill(N, 0); fr[$urandom_range(0, N - 1)] = 8'($urandom_range(1, 255)); send_frame(1'b1, 1'b1); end
      else             begin fill(N, 1); send_frame(1'b1, 1'b1); end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
